// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with overlap control and saturating match count.
// Optional SEQ_DET_MASK_EN adds per-bit don't-care mask input cfg_mask.
module seq_detect_param #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_vld,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    input  logic             clr_cnt,
    output logic             flag_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
`endif
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [PAT_W-1:0] hist_nx;
    logic [LEN_W-1:0] fill_nx;
    logic [PAT_W-1:0] lenmask;
    logic [PAT_W-1:0] diff;
    logic             hit;
    logic             match;

    always_comb begin
        hist_nx = {hist_q[PAT_W-2:0], data_in};
        fill_nx = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;

        lenmask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            lenmask[i] = (i < int'(len_q));
        end

`ifdef SEQ_DET_MASK_EN
        diff = (hist_nx ^ pat_q) & lenmask & ~mask_q;
`else
        diff = (hist_nx ^ pat_q) & lenmask;
`endif

        hit = data_vld && (len_q != '0) && (fill_nx >= len_q) && (diff == '0);
        // a config load discards the bit and any match in that same cycle
        match = hit && !cfg_load;
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
`ifdef SEQ_DET_MASK_EN
        mask_d = mask_q;
`endif
        hist_d = hist_q;
        fill_d = fill_q;
        flag_d = match;
        cnt_d  = cnt_q;

        if (cfg_load) begin
            pat_d  = cfg_pat;
            len_d  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            ovl_d  = cfg_ovl;
`ifdef SEQ_DET_MASK_EN
            mask_d = cfg_mask;
`endif
            hist_d = '0;
            fill_d = '0;
        end else if (data_vld) begin
            hist_d = hist_nx;
            fill_d = (match && !ovl_q) ? '0 : fill_nx;
        end

        if (clr_cnt) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b1;
`ifdef SEQ_DET_MASK_EN
            mask_q <= '0;
`endif
            hist_q <= '0;
            fill_q <= '0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
`ifdef SEQ_DET_MASK_EN
            mask_q <= mask_d;
`endif
            hist_q <= hist_d;
            fill_q <= fill_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign flag_out  = flag_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomized and directed bench for seq_detect_param against a queue-based reference model.
// Build with SEQ_DET_MASK_EN defined to also exercise the cfg_mask input.
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_in;
    logic             data_vld;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
`endif
    logic             clr_cnt;
    logic             flag_out;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    int total = 0;
    int bad   = 0;

    // reference model: the valid bits seen since the last clear
    bit         q[$];
    bit [7:0]   m_pat;
    int         m_len;
    bit         m_ovl;
    bit [7:0]   m_mask;
    int         exp_cnt;
    bit         exp_flag;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_vld (data_vld),
        .cfg_load (cfg_load),
        .cfg_pat  (cfg_pat),
        .cfg_len  (cfg_len),
        .cfg_ovl  (cfg_ovl),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask (cfg_mask),
`endif
        .clr_cnt  (clr_cnt),
        .flag_out (flag_out),
        .match_cnt(match_cnt),
        .cnt_sat  (cnt_sat)
    );

    task automatic model_reset();
        q.delete();
        m_pat    = '0;
        m_len    = 0;
        m_ovl    = 1'b1;
        m_mask   = '0;
        exp_cnt  = 0;
        exp_flag = 1'b0;
    endtask

    task automatic model_update();
        bit hit;
        int n;
        hit = 1'b0;
        if (cfg_load) begin
            m_pat = cfg_pat;
            m_len = (int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
            m_ovl = cfg_ovl;
`ifdef SEQ_DET_MASK_EN
            m_mask = cfg_mask;
`else
            m_mask = '0;
`endif
            q.delete();
        end else if (data_vld) begin
            q.push_back(data_in);
            if (q.size() > PAT_W) void'(q.pop_front());
            n = q.size();
            if (m_len > 0 && n >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (!m_mask[m_len-1-k] && q[n-m_len+k] != m_pat[m_len-1-k])
                        hit = 1'b0;
                end
            end
            if (hit && !m_ovl) q.delete();
        end
        if (clr_cnt) exp_cnt = hit ? 1 : 0;
        else if (hit && exp_cnt < CMAX) exp_cnt++;
        exp_flag = hit;
    endtask

    task automatic step(input logic v, input logic b, input logic ld, input logic clr);
        data_vld = v;
        data_in  = b;
        cfg_load = ld;
        clr_cnt  = clr;
        @(posedge clk);
        model_update();
        #1;
        data_vld = 1'b0;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] p, input int len, input logic ovl,
                            input logic [7:0] msk, input logic clr);
        cfg_pat = p;
        cfg_len = LEN_W'(len);
        cfg_ovl = ovl;
`ifdef SEQ_DET_MASK_EN
        cfg_mask = msk;
`else
        if (msk != 8'h00) $display("note: mask ignored in this build");
`endif
        step(1'b0, 1'b0, 1'b1, clr);
    endtask

    task automatic test_reset();
        total++;
        if (flag_out !== 1'b0 || match_cnt !== '0 || cnt_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got flag=%b cnt=%0d sat=%b want 0/0/0",
                     flag_out, match_cnt, cnt_sat);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s   = 7'b1011011;
        logic [6:0] exp = 7'b1001000;
        load_cfg(8'b0000_1101, 4, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s[i], 1'b0, 1'b0);
            total++;
            if (flag_out !== exp[i]) begin
                bad++;
                $display("FAIL ovl_flag bit%0d got=%b want=%b", i + 1, flag_out, exp[i]);
            end
        end
        total++;
        if (match_cnt !== CNT_W'(2)) begin
            bad++;
            $display("FAIL ovl_cnt got=%0d want=2", match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        logic [6:0] s   = 7'b1011011;
        logic [6:0] exp = 7'b0001000;
        logic [3:0] s2  = 4'b1011;
        load_cfg(8'b0000_1101, 4, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s[i], 1'b0, 1'b0);
            total++;
            if (flag_out !== exp[i]) begin
                bad++;
                $display("FAIL novl_flag bit%0d got=%b want=%b", i + 1, flag_out, exp[i]);
            end
        end
        total++;
        if (match_cnt !== CNT_W'(1)) begin
            bad++;
            $display("FAIL novl_cnt1 got=%0d want=1", match_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s2[i], 1'b0, 1'b0);
            total++;
            if (flag_out !== (i == 3)) begin
                bad++;
                $display("FAIL novl_flag2 bit%0d got=%b want=%b", i + 1, flag_out, i == 3);
            end
        end
        total++;
        if (match_cnt !== CNT_W'(2)) begin
            bad++;
            $display("FAIL novl_cnt2 got=%0d want=2", match_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] s = 4'b1011;
        load_cfg(8'b0000_1101, 4, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s[i], 1'b0, 1'b0);
            total++;
            if (flag_out !== (i == 3)) begin
                bad++;
                $display("FAIL gap_flag bit%0d got=%b want=%b", i + 1, flag_out, i == 3);
            end
            for (int g = 0; g < 3; g++) begin
                step(1'b0, ~s[i], 1'b0, 1'b0);
                total++;
                if (flag_out !== 1'b0) begin
                    bad++;
                    $display("FAIL gap_idle bit%0d got=%b want=0", i + 1, flag_out);
                end
            end
        end
        total++;
        if (match_cnt !== CNT_W'(1)) begin
            bad++;
            $display("FAIL gap_cnt got=%0d want=1", match_cnt);
        end
    endtask

    task automatic test_disable();
        int flags = 0;
        load_cfg(8'h00, 0, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (flag_out) flags++;
        end
        total++;
        if (flags != 0 || match_cnt !== '0) begin
            bad++;
            $display("FAIL disable got flags=%0d cnt=%0d want 0/0", flags, match_cnt);
        end
    endtask

    task automatic test_cfg_midpattern();
        logic [3:0] s = 4'b1011;
        load_cfg(8'b0000_1101, 4, 1'b1, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        data_in = 1'b1;
        load_cfg(8'b0000_1101, 4, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (flag_out !== 1'b0 || match_cnt !== '0) begin
            bad++;
            $display("FAIL midload got flag=%b cnt=%0d want 0/0", flag_out, match_cnt);
        end
        for (int i = 0; i < 4; i++) step(1'b1, s[i], 1'b0, 1'b0);
        total++;
        if (flag_out !== 1'b1 || match_cnt !== CNT_W'(1)) begin
            bad++;
            $display("FAIL midload_after got flag=%b cnt=%0d want 1/1", flag_out, match_cnt);
        end
    endtask

    task automatic test_saturation();
        load_cfg(8'b0000_0011, 2, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (match_cnt !== CNT_W'(CMAX) || cnt_sat !== 1'b1 || flag_out !== 1'b1) begin
            bad++;
            $display("FAIL sat got cnt=%0d sat=%b flag=%b want %0d/1/1",
                     match_cnt, cnt_sat, flag_out, CMAX);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (match_cnt !== CNT_W'(1) || cnt_sat !== 1'b0) begin
            bad++;
            $display("FAIL clr_match got cnt=%0d sat=%b want 1/0", match_cnt, cnt_sat);
        end
    endtask

    task automatic test_reset_midstream();
        logic [2:0] tail = 3'b101;
        load_cfg(8'b0000_1101, 4, 1'b1, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 3; i++) step(1'b1, tail[i], 1'b0, 1'b0);
        total++;
        if (match_cnt !== CNT_W'(exp_cnt) || exp_cnt != 5) begin
            bad++;
            $display("FAIL pre_reset got cnt=%0d want 5 (model %0d)", match_cnt, exp_cnt);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if (flag_out !== 1'b0 || match_cnt !== '0 || cnt_sat !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got flag=%b cnt=%0d sat=%b want 0/0/0",
                     flag_out, match_cnt, cnt_sat);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (flag_out !== 1'b0 || match_cnt !== '0) begin
            bad++;
            $display("FAIL post_reset got flag=%b cnt=%0d want 0/0", flag_out, match_cnt);
        end
    endtask

    task automatic test_random();
        int len;
        load_cfg(8'b0000_0101, 3, 1'b1, 8'h00, 1'b1);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
                cfg_pat = 8'($urandom);
                cfg_len = LEN_W'(len);
                cfg_ovl = 1'($urandom_range(0, 1));
`ifdef SEQ_DET_MASK_EN
                cfg_mask = 8'($urandom) & 8'($urandom);
`endif
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     $urandom_range(0, 29) == 0);
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0,
                     $urandom_range(0, 29) == 0);
            end
            total++;
            if (flag_out !== exp_flag || match_cnt !== CNT_W'(exp_cnt) ||
                cnt_sat !== (exp_cnt == CMAX)) begin
                bad++;
                $display("FAIL rand cyc%0d got flag=%b cnt=%0d sat=%b want %b/%0d/%b",
                         c, flag_out, match_cnt, cnt_sat, exp_flag, exp_cnt, exp_cnt == CMAX);
            end
        end
    endtask

`ifdef SEQ_DET_MASK_EN
    task automatic test_mask();
        logic [3:0] s [3];
        logic       want [3];
        s[0] = 4'b1111; want[0] = 1'b1;
        s[1] = 4'b1101; want[1] = 1'b1;
        s[2] = 4'b0111; want[2] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            load_cfg(8'b0000_1101, 4, 1'b0, 8'b0000_0010, 1'b1);
            for (int i = 3; i >= 0; i--) step(1'b1, s[t][i], 1'b0, 1'b0);
            total++;
            if (flag_out !== want[t] || flag_out !== exp_flag) begin
                bad++;
                $display("FAIL mask stream%0d got=%b want=%b", t, flag_out, want[t]);
            end
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        data_in  = 1'b0;
        data_vld = 1'b0;
        cfg_load = 1'b0;
        cfg_pat  = '0;
        cfg_len  = '0;
        cfg_ovl  = 1'b0;
`ifdef SEQ_DET_MASK_EN
        cfg_mask = '0;
`endif
        clr_cnt  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_disable();
        test_cfg_midpattern();
        test_saturation();
        test_reset_midstream();
`ifdef SEQ_DET_MASK_EN
        test_mask();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
